alu_controller: RTL and testbench

Sequencer that fronts the integer ALU with a valid/ready request/response interface. It latches the operands and a 4-bit opcode, then drives the ALU's 12-bit one-hot select for the required number of cycles. Single-cycle ops take 1 execute cycle; divide holds the select for DIV_CYCLES. It captures z/hi/lo into response registers and holds them until the consumer accepts. It sits between the control unit and the ALU, and guarantees divide select is deasserted between consecutive divides.

---
 rtl/alu_defs.sv | 33 +++
 rtl/alu_op_decoder.sv | 31 +++
 rtl/alu_controller.sv | 155 +++++++++++++++
 tb/tb_alu_controller.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs.sv
// Shared definitions for the ALU sequencer: opcodes, widths and FSM states.
package alu_defs;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;
  localparam int SEL_W  = 12;

  localparam logic [OP_W-1:0] OP_ADD = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB = 4'h1;
  localparam logic [OP_W-1:0] OP_SHR = 4'h2;
  localparam logic [OP_W-1:0] OP_SHL = 4'h3;
  localparam logic [OP_W-1:0] OP_ROR = 4'h4;
  localparam logic [OP_W-1:0] OP_ROL = 4'h5;
  localparam logic [OP_W-1:0] OP_AND = 4'h6;
  localparam logic [OP_W-1:0] OP_OR  = 4'h7;
  localparam logic [OP_W-1:0] OP_MUL = 4'h8;
  localparam logic [OP_W-1:0] OP_DIV = 4'h9;
  localparam logic [OP_W-1:0] OP_NEG = 4'hA;
  localparam logic [OP_W-1:0] OP_NOT = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DIV  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Opcodes above OP_NOT (C-F) have no ALU function behind them.
  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return (op > OP_NOT);
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Opcode to one-hot ALU select decoder; illegal opcodes produce an all-zero select.
module alu_op_decoder
  import alu_defs::*;
(
  input  logic [OP_W-1:0]  op,
  output logic [SEL_W-1:0] select,
  output logic             is_div,
  output logic             illegal
);

  // Bit index of the select equals the opcode for every legal operation.
  always_comb begin
    select  = '0;
    is_div  = 1'b0;
    illegal = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
      OP_AND, OP_OR, OP_MUL, OP_NEG, OP_NOT: begin
        select = SEL_W'(1) << op;
      end
      OP_DIV: begin
        select = SEL_W'(1) << op;
        is_div = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_controller.sv
// Valid/ready sequencer in front of the integer ALU: latches a request, drives the
// one-hot select for one cycle (or DIV_CYCLES for divide), captures z/hi/lo and
// holds the response until the consumer takes it.
module alu_controller
  import alu_defs::*;
#(
  parameter  int DIV_CYCLES = 34,
  localparam int CNT_BITS   = $clog2(DIV_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_select,
  input  logic [DATA_W-1:0] alu_z,
  input  logic [DATA_W-1:0] alu_hi,
  input  logic [DATA_W-1:0] alu_lo,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_z,
  output logic [DATA_W-1:0] resp_hi,
  output logic [DATA_W-1:0] resp_lo,
  output logic              resp_dbz,
  output logic              resp_illegal
);

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [OP_W-1:0]     op_q;
  logic [DATA_W-1:0]   z_q, hi_q, lo_q;
  logic                dbz_q, ill_q;

  logic                accept;
  logic                req_illegal;
  logic                req_dbz;
  logic                sel_en;
  logic                capture;
  logic [SEL_W-1:0]    dec_select;
  logic                dec_is_div;
  logic                dec_illegal;

  alu_op_decoder u_dec (
    .op      (op_q),
    .select  (dec_select),
    .is_div  (dec_is_div),
    .illegal (dec_illegal)
  );

  assign accept      = req_valid && (state_q == ST_IDLE);
  assign req_illegal = op_illegal(req_op);
  assign req_dbz     = !req_illegal && (req_op == OP_DIV) && (req_b == '0);

  // State and divide counter registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic, select enable and capture strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_en  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_illegal || req_dbz) begin
            state_d = ST_RESP;
          end else if (req_op == OP_DIV) begin
            state_d = ST_DIV;
            cnt_d   = CNT_BITS'(DIV_CYCLES - 1);
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        sel_en  = 1'b1;
        capture = 1'b1;
        state_d = ST_RESP;
      end
      ST_DIV: begin
        sel_en = 1'b1;
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Operand latch on accept; response capture from the ALU or early error response.
  always_ff @(posedge clk) begin
    if (clr) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      z_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      dbz_q <= 1'b0;
      ill_q <= 1'b0;
    end else if (accept) begin
      a_q   <= req_a;
      b_q   <= req_b;
      op_q  <= req_op;
      dbz_q <= req_dbz;
      ill_q <= req_illegal;
      if (req_illegal || req_dbz) begin
        z_q  <= '0;
        hi_q <= '0;
        lo_q <= '0;
      end
    end else if (capture) begin
      z_q  <= dec_is_div ? '0 : alu_z;
      hi_q <= alu_hi;
      lo_q <= alu_lo;
    end
  end

  // Select is zero outside EXEC/DIV, which guarantees a low gap between divides.
  assign alu_select   = (sel_en && !dec_illegal) ? dec_select : '0;
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign req_ready    = (state_q == ST_IDLE);
  assign resp_valid   = (state_q == ST_RESP);
  assign resp_z       = z_q;
  assign resp_hi      = hi_q;
  assign resp_lo      = lo_q;
  assign resp_dbz     = dbz_q;
  assign resp_illegal = ill_q;

endmodule

// File: tb/tb_alu_controller.sv
// Directed bench for alu_controller with a behavioural ALU stub and a response scoreboard.
module tb_alu_controller;

  localparam int DIV_CYCLES = 34;

  typedef struct packed {
    logic [31:0] z;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [31:0] alu_a, alu_b;
  logic [11:0] alu_select;
  logic [31:0] alu_z, alu_hi, alu_lo;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_z, resp_hi, resp_lo;
  logic        resp_dbz, resp_illegal;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   div_run = 0;

  alu_controller #(.DIV_CYCLES(DIV_CYCLES)) dut (
    .clk          (clk),
    .clr          (clr),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_select   (alu_select),
    .alu_z        (alu_z),
    .alu_hi       (alu_hi),
    .alu_lo       (alu_lo),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_z       (resp_z),
    .resp_hi      (resp_hi),
    .resp_lo      (resp_lo),
    .resp_dbz     (resp_dbz),
    .resp_illegal (resp_illegal)
  );

  always #5 clk = ~clk;

  // Divider stub: result only becomes valid once select bit 9 has been held DIV_CYCLES cycles.
  always @(posedge clk) begin
    div_run <= alu_select[9] ? div_run + 1 : 0;
  end

  // Behavioural ALU stub.
  always_comb begin
    logic [63:0] prod;
    prod   = '0;
    alu_z  = '0;
    alu_hi = '0;
    alu_lo = '0;
    case (alu_select)
      12'h001: alu_z = alu_a + alu_b;
      12'h002: alu_z = alu_a - alu_b;
      12'h004: alu_z = alu_a >> alu_b[4:0];
      12'h008: alu_z = alu_a << alu_b[4:0];
      12'h040: alu_z = alu_a & alu_b;
      12'h080: alu_z = alu_a | alu_b;
      12'h100: begin
        prod   = alu_a * alu_b;
        alu_hi = prod[63:32];
        alu_lo = prod[31:0];
      end
      12'h200: begin
        alu_z = 32'h5A5A_5A5A;
        if (div_run >= DIV_CYCLES - 1 && alu_b != 0) begin
          alu_hi = alu_a % alu_b;
          alu_lo = alu_a / alu_b;
        end else begin
          alu_hi = 32'hBAD0_BAD0;
          alu_lo = 32'hBAD0_BAD0;
        end
      end
      12'h400: alu_z = -alu_a;
      12'h800: alu_z = ~alu_a;
      default: alu_z = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "/alu_a"}, alu_a, 32'h0);
    chk({tag, "/alu_b"}, alu_b, 32'h0);
    chk({tag, "/alu_select"}, 32'(alu_select), 32'h0);
    chk({tag, "/resp_valid"}, 32'(resp_valid), 32'h0);
    chk({tag, "/resp_z"}, resp_z, 32'h0);
    chk({tag, "/resp_hi"}, resp_hi, 32'h0);
    chk({tag, "/resp_lo"}, resp_lo, 32'h0);
    chk({tag, "/resp_dbz"}, 32'(resp_dbz), 32'h0);
    chk({tag, "/resp_illegal"}, 32'(resp_illegal), 32'h0);
    chk({tag, "/req_ready"}, 32'(req_ready), 32'h1);
  endtask

  // Issue one request from IDLE (called at a negedge) and check the response on arrival.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [11:0] exp_sel,
                        input int exp_sel_cyc, input exp_t e);
    int   lat;
    int   sel_cyc;
    int   bad_sel;
    exp_t want;
    chk({tag, "/req_ready_idle"}, 32'(req_ready), 32'h1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    lat     = 1;
    sel_cyc = 0;
    bad_sel = 0;
    while (!resp_valid && lat < 200) begin
      if (alu_select == exp_sel) sel_cyc++;
      else if (alu_select != 0) bad_sel++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/select_cycles"}, 32'(sel_cyc), 32'(exp_sel_cyc));
    chk({tag, "/stray_select"}, 32'(bad_sel), 32'h0);
    chk({tag, "/select_in_resp"}, 32'(alu_select), 32'h0);
    chk({tag, "/req_ready_resp"}, 32'(req_ready), 32'h0);
    chk({tag, "/alu_a_held"}, alu_a, a);
    chk({tag, "/alu_b_held"}, alu_b, b);
    if (sb.size() == 0) begin
      chk({tag, "/scoreboard_empty"}, 32'h0, 32'h1);
    end else begin
      want = sb.pop_front();
      chk({tag, "/resp_z"}, resp_z, want.z);
      chk({tag, "/resp_hi"}, resp_hi, want.hi);
      chk({tag, "/resp_lo"}, resp_lo, want.lo);
      chk({tag, "/resp_dbz"}, 32'(resp_dbz), 32'(want.dbz));
      chk({tag, "/resp_illegal"}, 32'(resp_illegal), 32'(want.ill));
    end
  endtask

  // With resp_ready high, the controller must be back in IDLE one cycle after the response.
  task automatic finish_resp(input string tag, input logic [31:0] z_keep);
    @(negedge clk);
    chk({tag, "/resp_valid_drop"}, 32'(resp_valid), 32'h0);
    chk({tag, "/req_ready_back"}, 32'(req_ready), 32'h1);
    chk({tag, "/resp_z_persist"}, resp_z, z_keep);
  endtask

  initial begin
    int seen;

    // Reset
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;

    // Single-cycle operations
    run_op("add", 4'h0, 32'd124, 32'd7, 2, 12'h001, 1, '{z: 32'd131, hi: 0, lo: 0, dbz: 0, ill: 0});
    finish_resp("add", 32'd131);
    run_op("mul", 4'h8, 32'd124, 32'd7, 2, 12'h100, 1, '{z: 0, hi: 0, lo: 32'd868, dbz: 0, ill: 0});
    finish_resp("mul", 32'd0);
    run_op("shr", 4'h2, 32'd124, 32'd2, 2, 12'h004, 1, '{z: 32'd31, hi: 0, lo: 0, dbz: 0, ill: 0});
    finish_resp("shr", 32'd31);

    // Back-to-back divides
    run_op("div1", 4'h9, 32'd100, 32'd7, 1 + DIV_CYCLES, 12'h200, DIV_CYCLES,
           '{z: 0, hi: 32'd2, lo: 32'd14, dbz: 0, ill: 0});
    finish_resp("div1", 32'd0);
    run_op("div2", 4'h9, 32'd50, 32'd5, 1 + DIV_CYCLES, 12'h200, DIV_CYCLES,
           '{z: 0, hi: 32'd0, lo: 32'd10, dbz: 0, ill: 0});
    finish_resp("div2", 32'd0);

    // Divide by zero and illegal opcode respond immediately
    run_op("dbz", 4'h9, 32'd5, 32'd0, 1, 12'h000, 0, '{z: 0, hi: 0, lo: 0, dbz: 1, ill: 0});
    finish_resp("dbz", 32'd0);
    run_op("illegal", 4'hC, 32'd124, 32'd7, 1, 12'h000, 0, '{z: 0, hi: 0, lo: 0, dbz: 0, ill: 1});
    finish_resp("illegal", 32'd0);

    // Backpressure on the response side
    resp_ready = 1'b0;
    run_op("sub_bp", 4'h1, 32'd124, 32'd7, 2, 12'h002, 1, '{z: 32'd117, hi: 0, lo: 0, dbz: 0, ill: 0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp/resp_valid", 32'(resp_valid), 32'h1);
      chk("bp/resp_z", resp_z, 32'd117);
      chk("bp/req_ready", 32'(req_ready), 32'h0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp/req_ready_release", 32'(req_ready), 32'h1);
    chk("bp/resp_valid_release", 32'(resp_valid), 32'h0);

    // Reset in the middle of a divide discards it
    req_valid = 1'b1;
    req_op    = 4'h9;
    req_a     = 32'd100;
    req_b     = 32'd7;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("middiv/select_before_clr", 32'(alu_select), 32'h200);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("middiv");
    clr = 1'b0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("middiv/no_response", 32'(seen), 32'h0);
    chk("middiv/req_ready_idle", 32'(req_ready), 32'h1);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
